agc_lane_engine: RTL and testbench

- Parametrised successor to the single-sample AGC DSP slice.
- Each clock, applies offset-then-scale AGC to NSAMP parallel samples and saturates each to NBITS signed.
- Double-buffers the shared scale and offset so both update together on an `apply` strobe.
- Measures the output over a programmable window (sum of squares, saturation counts) with a start/done/ack handshake, so the software AGC loop can servo scale and offset.
- Sits between the RFDC sample stream and the trigger beamformer, one instance per channel.

---
 rtl/agc_lane_engine_if.sv | 54 +++++
 rtl/agc_lane_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_agc_lane_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/agc_lane_engine_if.sv
// rtl/agc_lane_engine_if.sv - sample stream, coefficient and measurement bundle for agc_lane_engine
//
// Groups every non-clock/reset port of agc_lane_engine:
//   dat_i                      NSAMP packed signed input samples
//   scale_i/ce_scale_i         unsigned scale into staging
//   offset_i/ce_offset_i       signed offset into staging
//   apply_i                    staging -> active for scale and offset together
//   window_i/start_i/ack_i     measurement window request and handshake
//   out_o/abs_o/gt_o/lt_o      saturated outputs, magnitudes, saturation flags
//   busy_o/done_o              measurement status
//   sumsq_o/gt_cnt_o/lt_cnt_o  measurement results
// slave is the engine side, master is the driving side.
interface agc_lane_engine_if #(
  parameter int NSAMP       = 8,
  parameter int DAT_BITS    = 12,
  parameter int OFFSET_BITS = 12,
  parameter int NBITS       = 5,
  parameter int WIN_BITS    = 16
);
  localparam int LG      = $clog2(NSAMP);
  localparam int SUMSQ_W = 2*NBITS-1+LG+WIN_BITS;
  localparam int CNT_W   = LG+WIN_BITS+1;

  logic [NSAMP*DAT_BITS-1:0]  dat_i;
  logic [16:0]                scale_i;
  logic                       ce_scale_i;
  logic [OFFSET_BITS-1:0]     offset_i;
  logic                       ce_offset_i;
  logic                       apply_i;
  logic [WIN_BITS-1:0]        window_i;
  logic                       start_i;
  logic                       ack_i;
  logic [NSAMP*NBITS-1:0]     out_o;
  logic [NSAMP*(NBITS-1)-1:0] abs_o;
  logic [NSAMP-1:0]           gt_o;
  logic [NSAMP-1:0]           lt_o;
  logic                       busy_o;
  logic                       done_o;
  logic [SUMSQ_W-1:0]         sumsq_o;
  logic [CNT_W-1:0]           gt_cnt_o;
  logic [CNT_W-1:0]           lt_cnt_o;

  modport slave (
    input  dat_i, scale_i, ce_scale_i, offset_i, ce_offset_i, apply_i,
           window_i, start_i, ack_i,
    output out_o, abs_o, gt_o, lt_o, busy_o, done_o, sumsq_o, gt_cnt_o, lt_cnt_o
  );

  modport master (
    output dat_i, scale_i, ce_scale_i, offset_i, ce_offset_i, apply_i,
           window_i, start_i, ack_i,
    input  out_o, abs_o, gt_o, lt_o, busy_o, done_o, sumsq_o, gt_cnt_o, lt_cnt_o
  );
endinterface

// File: rtl/agc_lane_engine.sv
// rtl/agc_lane_engine.sv - NSAMP-lane offset/scale AGC with saturation and windowed power measurement
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     agc_lane_engine_if.slave (sample stream, coefficients, measurement)
// Pipeline: sum -> product -> shifted result -> saturated outputs (4 clocks).
module agc_lane_engine #(
  parameter int NSAMP       = 8,
  parameter int DAT_BITS    = 12,
  parameter int Q_DAT       = 0,
  parameter int OFFSET_BITS = 12,
  parameter int Q_OFFSET    = 8,
  parameter int Q_SCALE     = 12,
  parameter int SCALE_IN    = 5,
  parameter int NFRAC_OUT   = 2,
  parameter int NBITS       = 5,
  parameter int WIN_BITS    = 16,
  parameter int SCALE_RESET = 4096
) (
  input logic              clk_i,
  input logic              rst_ni,
  agc_lane_engine_if.slave bus
);
  localparam int Q_SUM   = (Q_DAT > Q_OFFSET) ? Q_DAT : Q_OFFSET;
  localparam int SH_D    = Q_SUM - Q_DAT;
  localparam int SH_O    = Q_SUM - Q_OFFSET;
  localparam int LSB     = Q_SUM + Q_SCALE + SCALE_IN - NFRAC_OUT;
  localparam int W_D     = DAT_BITS + SH_D;
  localparam int W_O     = OFFSET_BITS + SH_O;
  // One guard bit keeps dat+offset exact.
  localparam int SUM_W   = ((W_D > W_O) ? W_D : W_O) + 1;
  localparam int PROD_W  = SUM_W + 18;
  localparam int Y_W     = PROD_W - LSB;
  localparam int LG      = $clog2(NSAMP);
  localparam int CSQ_W   = 2*NBITS-1+LG;
  localparam int CCNT_W  = LG+1;
  localparam int SUMSQ_W = CSQ_W+WIN_BITS;
  localparam int CNT_W   = CCNT_W+WIN_BITS;

  localparam logic [NBITS-1:0] OMAX    = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] OMIN    = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-2:0] ABS_MAX = {(NBITS-1){1'b1}};
  localparam logic [16:0]      SCALE_RST = 17'(SCALE_RESET);
  localparam logic [WIN_BITS-1:0] WIN_ONE = WIN_BITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  // Coefficients: staging written by ce_*, active written by apply_i.
  logic [16:0]            scale_stg_q, scale_act_q;
  logic [OFFSET_BITS-1:0] off_stg_q, off_act_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scale_stg_q <= SCALE_RST;
      scale_act_q <= SCALE_RST;
      off_stg_q   <= '0;
      off_act_q   <= '0;
    end else begin
      if (bus.ce_scale_i)  scale_stg_q <= bus.scale_i;
      if (bus.ce_offset_i) off_stg_q   <= bus.offset_i;
      // Reads the pre-edge staging, so a same-cycle ce lands one apply later.
      if (bus.apply_i) begin
        scale_act_q <= scale_stg_q;
        off_act_q   <= off_stg_q;
      end
    end
  end

  // Stage 1: align binary points and add offset.
  logic [SUM_W-1:0] sum_d [NSAMP];
  logic [SUM_W-1:0] off_ext;

  always_comb begin
    sum_d   = '{default: '0};
    off_ext = {{(SUM_W-OFFSET_BITS){off_act_q[OFFSET_BITS-1]}}, off_act_q} << SH_O;
    for (int k = 0; k < NSAMP; k++) begin
      sum_d[k] = ({{(SUM_W-DAT_BITS){bus.dat_i[k*DAT_BITS+DAT_BITS-1]}},
                   bus.dat_i[k*DAT_BITS +: DAT_BITS]} << SH_D) + off_ext;
    end
  end

  // The scale travels with its samples so an apply never splits a sample's math.
  logic [SUM_W-1:0]  sum_q  [NSAMP];
  logic [16:0]       scale_p_q;
  logic [PROD_W-1:0] prod_q [NSAMP];
  logic [Y_W-1:0]    y_q    [NSAMP];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q     <= '{default: '0};
      scale_p_q <= '0;
      prod_q    <= '{default: '0};
      y_q       <= '{default: '0};
    end else begin
      scale_p_q <= scale_act_q;
      for (int k = 0; k < NSAMP; k++) begin
        sum_q[k]  <= sum_d[k];
        // Operands extended to full width: the low PROD_W bits are the exact signed product.
        prod_q[k] <= {{(PROD_W-SUM_W){sum_q[k][SUM_W-1]}}, sum_q[k]} *
                     {{(PROD_W-17){1'b0}}, scale_p_q};
        // Dropping LSB bits of a two's-complement value is floor division.
        y_q[k]    <= prod_q[k][PROD_W-1:LSB];
      end
    end
  end

  // Stage 4: saturate, flag and take magnitude.
  logic [NSAMP*NBITS-1:0]     out_d, out_q;
  logic [NSAMP*(NBITS-1)-1:0] abs_d, abs_q;
  logic [NSAMP-1:0]           gt_d, gt_q, lt_d, lt_q;
  logic [Y_W-NBITS:0]         hi;
  logic [NBITS-1:0]           o_v, neg_v;

  always_comb begin
    out_d = '0;
    abs_d = '0;
    gt_d  = '0;
    lt_d  = '0;
    hi    = '0;
    o_v   = '0;
    neg_v = '0;
    for (int k = 0; k < NSAMP; k++) begin
      // In range exactly when every bit above the output sign matches it.
      hi = y_q[k][Y_W-1:NBITS-1];
      if ((hi != '0) && (hi != '1)) begin
        gt_d[k] = ~y_q[k][Y_W-1];
        lt_d[k] = y_q[k][Y_W-1];
        o_v     = y_q[k][Y_W-1] ? OMIN : OMAX;
      end else begin
        o_v = y_q[k][NBITS-1:0];
      end
      neg_v = -o_v;
      out_d[k*NBITS +: NBITS] = o_v;
      abs_d[k*(NBITS-1) +: NBITS-1] = (o_v == OMIN) ? ABS_MAX :
                                      (o_v[NBITS-1] ? neg_v[NBITS-2:0] : o_v[NBITS-2:0]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      abs_q <= '0;
      gt_q  <= '0;
      lt_q  <= '0;
    end else begin
      out_q <= out_d;
      abs_q <= abs_d;
      gt_q  <= gt_d;
      lt_q  <= lt_d;
    end
  end

  // Per-clock totals over the lanes currently on out_q.
  logic [CSQ_W-1:0]     clk_sq;
  logic [CCNT_W-1:0]    clk_gt, clk_lt;
  logic [2*NBITS-1:0]   lane_v, lane_sq;

  always_comb begin
    clk_sq  = '0;
    clk_gt  = '0;
    clk_lt  = '0;
    lane_v  = '0;
    lane_sq = '0;
    for (int k = 0; k < NSAMP; k++) begin
      lane_v  = {{NBITS{out_q[k*NBITS+NBITS-1]}}, out_q[k*NBITS +: NBITS]};
      lane_sq = lane_v * lane_v;
      clk_sq  = clk_sq + CSQ_W'(lane_sq[2*NBITS-2:0]);
      clk_gt  = clk_gt + CCNT_W'(gt_q[k]);
      clk_lt  = clk_lt + CCNT_W'(lt_q[k]);
    end
  end

  // Measurement FSM.
  state_t              state_q, state_d;
  logic [WIN_BITS-1:0] left_q, left_d;
  logic [SUMSQ_W-1:0]  sumsq_q, sumsq_d;
  logic [CNT_W-1:0]    gtc_q, gtc_d, ltc_q, ltc_d;
  logic                load;

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    sumsq_d = sumsq_q;
    gtc_d   = gtc_q;
    ltc_d   = ltc_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: load = bus.start_i;
      S_ACCUM: begin
        sumsq_d = sumsq_q + SUMSQ_W'(clk_sq);
        gtc_d   = gtc_q + CNT_W'(clk_gt);
        ltc_d   = ltc_q + CNT_W'(clk_lt);
        left_d  = left_q - WIN_ONE;
        if (left_q == WIN_ONE) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.ack_i) begin
          state_d = S_IDLE;
          load    = bus.start_i;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d = S_ACCUM;
      left_d  = (bus.window_i == '0) ? WIN_ONE : bus.window_i;
      sumsq_d = '0;
      gtc_d   = '0;
      ltc_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      left_q  <= '0;
      sumsq_q <= '0;
      gtc_q   <= '0;
      ltc_q   <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      sumsq_q <= sumsq_d;
      gtc_q   <= gtc_d;
      ltc_q   <= ltc_d;
    end
  end

  assign bus.out_o    = out_q;
  assign bus.abs_o    = abs_q;
  assign bus.gt_o     = gt_q;
  assign bus.lt_o     = lt_q;
  assign bus.busy_o   = (state_q == S_ACCUM);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.sumsq_o  = sumsq_q;
  assign bus.gt_cnt_o = gtc_q;
  assign bus.lt_cnt_o = ltc_q;
endmodule

// File: tb/tb_agc_lane_engine.sv
// tb/tb_agc_lane_engine.sv - self-checking bench for agc_lane_engine
module tb_agc_lane_engine;
  localparam int NS = 8;
  localparam int DB = 12;
  localparam int NB = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  agc_lane_engine_if bus ();
  agc_lane_engine dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS*NB-1:0]     o;
    logic [NS*(NB-1)-1:0] a;
    logic [NS-1:0]        g;
    logic [NS-1:0]        l;
  } exp_t;

  exp_t   pq[$];
  exp_t   vis;
  int     m_scale_stg, m_scale_act, m_off_stg, m_off_act;
  int     m_st, m_left, m_gtc, m_ltc;
  longint m_sumsq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Outputs visible after reset come from an all-zero pipeline.
  task automatic model_reset();
    pq.delete();
    repeat (3) pq.push_back('0);
    vis = '0;
    m_scale_stg = 4096; m_scale_act = 4096;
    m_off_stg = 0; m_off_act = 0;
    m_st = 0; m_left = 0;
    m_sumsq = 0; m_gtc = 0; m_ltc = 0;
  endtask

  // out = sat(floor((dat*2^8 + off) * scale / 2^23))
  function automatic exp_t model_lanes(input logic [NS*DB-1:0] dat, input int scale, input int off);
    exp_t e;
    e = '0;
    for (int k = 0; k < NS; k++) begin
      int d, o, a;
      longint p, y;
      d = $signed(dat[k*DB +: DB]);
      p = (longint'(d) * 256 + longint'(off)) * longint'(scale);
      y = p >>> 23;
      if (y > 15) begin o = 15; e.g[k] = 1'b1; end
      else if (y < -16) begin o = -16; e.l[k] = 1'b1; end
      else o = int'(y);
      a = (o == -16) ? 15 : ((o < 0) ? -o : o);
      e.o[k*NB +: NB] = o[NB-1:0];
      e.a[k*(NB-1) +: NB-1] = a[NB-2:0];
    end
    return e;
  endfunction

  task automatic check_all();
    chk("out", bus.out_o, vis.o);
    chk("abs", bus.abs_o, vis.a);
    chk("gt", bus.gt_o, vis.g);
    chk("lt", bus.lt_o, vis.l);
    chk("busy", bus.busy_o, m_st == 1);
    chk("done", bus.done_o, m_st == 2);
    chk("sumsq", bus.sumsq_o, m_sumsq);
    chk("gt_cnt", bus.gt_cnt_o, m_gtc);
    chk("lt_cnt", bus.lt_cnt_o, m_ltc);
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    if (!rst_n) begin
      model_reset();
    end else begin
      pq.push_back(model_lanes(bus.dat_i, m_scale_act, m_off_act));
      if (m_st == 1) begin
        for (int k = 0; k < NS; k++) begin
          int v;
          v = $signed(vis.o[k*NB +: NB]);
          m_sumsq += v * v;
          m_gtc += int'(vis.g[k]);
          m_ltc += int'(vis.l[k]);
        end
        m_left--;
        if (m_left == 0) m_st = 2;
      end else if (bus.start_i && (m_st == 0 || (m_st == 2 && bus.ack_i))) begin
        m_st = 1;
        m_left = (bus.window_i == 0) ? 1 : int'(bus.window_i);
        m_sumsq = 0; m_gtc = 0; m_ltc = 0;
      end else if (m_st == 2 && bus.ack_i) begin
        m_st = 0;
      end
      if (bus.apply_i) begin
        m_scale_act = m_scale_stg;
        m_off_act = m_off_stg;
      end
      if (bus.ce_scale_i) m_scale_stg = int'(bus.scale_i);
      if (bus.ce_offset_i) m_off_stg = int'($signed(bus.offset_i));
    end
    @(posedge clk);
    #1;
    if (rst_n) vis = pq.pop_front();
    else vis = '0;
    check_all();
  endtask

  task automatic set_lane(input int k, input int v);
    bus.dat_i[k*DB +: DB] = v[DB-1:0];
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < NS; k++) set_lane(k, v);
  endtask

  function automatic logic [NB-1:0] lane(input int k);
    return bus.out_o[k*NB +: NB];
  endfunction

  task automatic run_window(input string tag, input int expect_len);
    int n;
    n = 0;
    while (!bus.done_o && n < 300) begin
      bus.start_i = (n == 3);
      step();
      n++;
    end
    bus.start_i = 1'b0;
    chk(tag, n, expect_len);
  endtask

  initial begin
    bus.dat_i = '0; bus.scale_i = '0; bus.ce_scale_i = 0; bus.offset_i = '0;
    bus.ce_offset_i = 0; bus.apply_i = 0; bus.window_i = '0; bus.start_i = 0; bus.ack_i = 0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_out", bus.out_o, 0);
    chk("rst_done", bus.done_o, 0);

    // Basic scaling and 4-clock latency.
    set_all(0);
    set_lane(0, 32); set_lane(1, -1); set_lane(2, 8); set_lane(3, 0);
    repeat (3) step();
    chk("lat_early_l0", lane(0), 0);
    step();
    chk("tp_l0", lane(0), 5'd4);
    chk("tp_l1", lane(1), 5'h1f);
    chk("tp_l2", lane(2), 5'd1);
    chk("tp_l3", lane(3), 5'd0);

    // Saturation both ways.
    set_all(200); repeat (4) step();
    chk("sat_pos", lane(0), 5'd15);
    chk("sat_gt", bus.gt_o, 8'hff);
    chk("sat_abs_pos", bus.abs_o[3:0], 4'hf);
    set_all(-200); repeat (4) step();
    chk("sat_neg", lane(0), 5'h10);
    chk("sat_lt", bus.lt_o, 8'hff);
    chk("sat_abs_neg", bus.abs_o[3:0], 4'hf);

    // Staging without apply, then apply boundary.
    set_all(32);
    bus.scale_i = 17'd8192; bus.ce_scale_i = 1; step(); bus.ce_scale_i = 0;
    repeat (4) step();
    chk("stage_only", lane(0), 5'd4);
    bus.apply_i = 1; step(); bus.apply_i = 0;
    repeat (3) step();
    chk("apply_same_sample", lane(0), 5'd4);
    step();
    chk("apply_next_sample", lane(0), 5'd8);

    // Back to unity, then ce+apply together.
    bus.scale_i = 17'd4096; bus.ce_scale_i = 1; step(); bus.ce_scale_i = 0;
    bus.apply_i = 1; step(); bus.apply_i = 0;
    set_all(7);
    bus.offset_i = 12'd256; bus.ce_offset_i = 1; bus.apply_i = 1; step();
    bus.ce_offset_i = 0; bus.apply_i = 0;
    repeat (4) step();
    chk("ce_apply_same", lane(0), 5'd0);
    bus.apply_i = 1; step(); bus.apply_i = 0;
    repeat (4) step();
    chk("offset_applied", lane(0), 5'd1);
    bus.offset_i = '0; bus.ce_offset_i = 1; step(); bus.ce_offset_i = 0;
    bus.apply_i = 1; step(); bus.apply_i = 0;

    // Window of 100 with constant 32s, start during busy ignored.
    set_all(32); bus.window_i = 16'd100;
    repeat (4) step();
    bus.start_i = 1; step(); bus.start_i = 0;
    chk("win_busy", bus.busy_o, 1);
    run_window("win100_len", 100);
    chk("win100_sumsq", bus.sumsq_o, 12800);
    chk("win100_gt", bus.gt_cnt_o, 0);
    chk("win100_lt", bus.lt_cnt_o, 0);
    bus.start_i = 1; repeat (5) step(); bus.start_i = 0;
    chk("done_hold", bus.done_o, 1);
    bus.ack_i = 1; step(); bus.ack_i = 0;
    chk("ack_drop", bus.done_o, 0);

    // Alternating saturation, then ack+start restart.
    for (int k = 0; k < NS; k++) set_lane(k, (k % 2 == 0) ? 200 : -200);
    bus.window_i = 16'd10;
    repeat (4) step();
    bus.start_i = 1; step(); bus.start_i = 0;
    run_window("win10_len", 10);
    chk("win10_sumsq", bus.sumsq_o, 19240);
    chk("win10_gt", bus.gt_cnt_o, 40);
    chk("win10_lt", bus.lt_cnt_o, 40);
    bus.ack_i = 1; bus.start_i = 1; step(); bus.ack_i = 0; bus.start_i = 0;
    chk("restart_busy", bus.busy_o, 1);
    run_window("restart_len", 10);
    chk("restart_sumsq", bus.sumsq_o, 19240);
    bus.ack_i = 1; step(); bus.ack_i = 0;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NS; k++) bus.dat_i[k*DB +: DB] = 12'($urandom);
      bus.ce_scale_i  = ($urandom_range(0, 15) == 0);
      bus.scale_i     = 17'($urandom_range(0, 20000));
      bus.ce_offset_i = ($urandom_range(0, 15) == 0);
      bus.offset_i    = 12'($urandom);
      bus.apply_i     = ($urandom_range(0, 7) == 0);
      bus.start_i     = ($urandom_range(0, 5) == 0);
      bus.ack_i       = ($urandom_range(0, 3) == 0);
      bus.window_i    = 16'($urandom_range(0, 12));
      step();
    end
    bus.ce_scale_i = 0; bus.ce_offset_i = 0; bus.apply_i = 0; bus.start_i = 0;
    bus.ack_i = 1; step(); bus.ack_i = 0;

    // Reset in the middle of a window with a non-default active scale.
    set_all(32);
    bus.scale_i = 17'd8192; bus.ce_scale_i = 1; step(); bus.ce_scale_i = 0;
    bus.apply_i = 1; step(); bus.apply_i = 0;
    bus.window_i = 16'd50;
    bus.start_i = 1; step(); bus.start_i = 0;
    repeat (10) step();
    chk("pre_rst_busy", bus.busy_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", bus.out_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_sumsq", bus.sumsq_o, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_rst_scale", lane(0), 5'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
